// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the glyph pixel stage.
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
    logic       pix_en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       bright;
    logic       frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    modport master (
        output pix_en, hcount, vcount, hsync, vsync, bright, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
        , frame_cnt
`endif
    );

    modport slave (
        input pix_en, hcount, vcount, hsync, vsync, bright, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
        , frame_cnt
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, registered sync/bright decode.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int CLK_DIV        = 2,
    parameter int H_TOTAL        = 800,
    parameter int H_SYNC         = 96,
    parameter int H_ACTIVE_START = 158,
    parameter int H_ACTIVE       = 640,
    parameter int V_TOTAL        = 525,
    parameter int V_ACTIVE       = 480,
    parameter int V_SYNC_START   = 490,
    parameter int V_SYNC         = 2
) (
    input logic             clk,
    input logic             rst,
    vga_timing_gen_if.master vga
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_ACTIVE_START + H_ACTIVE > H_TOTAL || H_TOTAL > 1024) begin : g_bad_h
        $error("vga_timing_gen: horizontal timing parameters out of range");
    end
    if (V_SYNC_START + V_SYNC > V_TOTAL || V_TOTAL > 1024 || V_ACTIVE > V_SYNC_START) begin : g_bad_v
        $error("vga_timing_gen: vertical timing parameters out of range");
    end

    // Decode uses an 11-bit compare so limits equal to 1024 stay representable.
    function automatic logic hsync_of(input logic [9:0] h);
        return !({1'b0, h} < 11'(H_SYNC));
    endfunction

    function automatic logic vsync_of(input logic [9:0] v);
        return !(({1'b0, v} >= 11'(V_SYNC_START)) &&
                 ({1'b0, v} <  11'(V_SYNC_START + V_SYNC)));
    endfunction

    function automatic logic bright_of(input logic [9:0] h, input logic [9:0] v);
        return ({1'b0, h} >= 11'(H_ACTIVE_START)) &&
               ({1'b0, h} <  11'(H_ACTIVE_START + H_ACTIVE)) &&
               ({1'b0, v} <  11'(V_ACTIVE));
    endfunction

    logic [DIV_W-1:0] div;
    logic             div_last;
    logic             pix_en;
    logic [9:0]       hcount;
    logic [9:0]       vcount;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             h_wrap;
    logic             v_wrap;
    logic             hsync;
    logic             vsync;
    logic             bright;
    logic             frame_start;

    assign div_last = (div == DIV_W'(CLK_DIV - 1));

    always_comb begin
        h_wrap = (hcount == 10'(H_TOTAL - 1));
        v_wrap = (vcount == 10'(V_TOTAL - 1));
        h_next = h_wrap ? 10'd0 : hcount + 10'd1;
        v_next = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : vcount + 10'd1;
        end
    end

    // Sync/bright are decoded from the next-state counters so they line up with them.
    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            pix_en      <= 1'b0;
            hcount      <= 10'd0;
            vcount      <= 10'd0;
            hsync       <= 1'b0;
            vsync       <= 1'b1;
            bright      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_last ? '0 : div + 1'b1;
            pix_en      <= div_last;
            frame_start <= 1'b0;
            if (pix_en) begin
                hcount      <= h_next;
                vcount      <= v_next;
                hsync       <= hsync_of(h_next);
                vsync       <= vsync_of(v_next);
                bright      <= bright_of(h_next, v_next);
                frame_start <= h_wrap && v_wrap;
            end
        end
    end

    assign vga.pix_en      = pix_en;
    assign vga.hcount      = hcount;
    assign vga.vcount      = vcount;
    assign vga.hsync       = hsync;
    assign vga.vsync       = vsync;
    assign vga.bright      = bright;
    assign vga.frame_start = frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (pix_en && h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign vga.frame_cnt = frame_cnt;
`endif
endmodule
